// File: rtl/fir_coef_loader_if.sv
// Coefficient stream in, FIR coefficient-bank write port out.
// The loader takes the slave view; the config source and FIR side take the master view.
interface fir_coef_loader_if #(
    parameter int COEF_WIDTH = 24,
    parameter int ADDR_WIDTH = 3
);
    logic signed [COEF_WIDTH-1:0] s_coef_in;
    logic                         s_valid_in;
    logic                         s_ready_out;
    logic        [ADDR_WIDTH-1:0] coef_addr_out;
    logic signed [COEF_WIDTH-1:0] coef_out;
    logic                         we_out;

    modport slave (
        input  s_coef_in, s_valid_in,
        output s_ready_out, coef_addr_out, coef_out, we_out
    );

    modport master (
        output s_coef_in, s_valid_in,
        input  s_ready_out, coef_addr_out, coef_out, we_out
    );
endinterface

// File: rtl/fir_coef_loader.sv
// Streams NUM_TAPS coefficients into the FIR coefficient bank at addresses 0..NUM_TAPS-1,
// optionally throttled by GAP_CYCLES idle cycles after each write.
module fir_coef_loader #(
    parameter int NUM_TAPS   = 6,
    parameter int COEF_WIDTH = 24,
    parameter int ADDR_WIDTH = 3,
    parameter int GAP_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_in,
    input  logic                abort_in,
    fir_coef_loader_if.slave    bus,
    output logic                busy_out,
    output logic                done_out,
    output logic                err_out
);

    typedef enum logic [1:0] {IDLE, LOAD, GAP, DONE} state_t;

    state_t                       state_q, state_d;
    logic        [ADDR_WIDTH-1:0] index_q, index_d;
    logic        [3:0]            gap_q, gap_d;
    logic                         ready_q, ready_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;
    logic                         we_q, we_d;
    logic        [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic signed [COEF_WIDTH-1:0] coef_q, coef_d;

    logic hs;
    logic last;

    // abort_in must block a handshake in the very cycle it is raised
    assign hs   = ready_q & ~abort_in & bus.s_valid_in;
    assign last = (index_q == ADDR_WIDTH'(NUM_TAPS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            index_q <= '0;
            gap_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            coef_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            gap_q   <= gap_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            coef_q  <= coef_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (start_in && !abort_in) begin
                    state_d = LOAD;
                    index_d = '0;
                end
            end
            LOAD: begin
                if (abort_in) begin
                    state_d = IDLE;
                end else if (hs) begin
                    index_d = index_q + 1'b1;
                    if (last) begin
                        state_d = DONE;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        gap_d   = 4'(GAP_CYCLES - 1);
                    end
                end
            end
            GAP: begin
                if (abort_in) begin
                    state_d = IDLE;
                end else if (gap_q == 4'd0) begin
                    state_d = LOAD;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state
    always_comb begin
        ready_d = (state_d == LOAD);
        busy_d  = (state_d != IDLE);
        done_d  = (state_q == DONE);
        we_d    = hs;
        addr_d  = hs ? index_q : addr_q;
        coef_d  = hs ? bus.s_coef_in : coef_q;
        err_d   = err_q;
        if (state_q == IDLE) begin
            if (start_in && !abort_in) begin
                err_d = 1'b0;
            end
        end else if (start_in) begin
            err_d = 1'b1;
        end
    end

    assign bus.s_ready_out   = ready_q & ~abort_in;
    assign bus.coef_addr_out = addr_q;
    assign bus.coef_out      = coef_q;
    assign bus.we_out        = we_q;
    assign busy_out          = busy_q;
    assign done_out          = done_q;
    assign err_out           = err_q;

endmodule
